// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction field layout
// and FSM state encoding.
package alu_pkg;

   localparam int DATA_W  = 4;
   localparam int ADDR_W  = 2;
   localparam int REG_N   = 4;
   localparam int OP_W    = 3;
   localparam int INSTR_W = 10;

   // in_instr = {ld, op[2:0], rd[1:0], rs1[1:0], rs2[1:0]}; imm = {rs1, rs2}
   localparam int LD_POS  = 9;
   localparam int OP_LSB  = 6;
   localparam int RD_LSB  = 4;
   localparam int RS1_LSB = 2;
   localparam int RS2_LSB = 0;
   localparam int IMM_LSB = 0;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
   localparam logic [OP_W-1:0] OP_OR   = 3'b011;
   localparam logic [OP_W-1:0] OP_AND  = 3'b100;
   localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
   localparam logic [OP_W-1:0] OP_NAND = 3'b110;
   localparam logic [OP_W-1:0] OP_XNOR = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   // The ALU carry output only has meaning for arithmetic opcodes.
   function automatic logic carry_valid(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/regfile4x4.sv
// 4 x 4-bit register file: two combinational read ports, one synchronous
// write port, asynchronous active-low clear.
module regfile4x4
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs [REG_N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer for an external 4-bit combinational ALU: accepts instructions,
// drives the ALU pins for one cycle, writes back and returns the result.
module alu_sequencer
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [DATA_W-1:0]  res_data,
   output logic               res_cout,
   output logic [ADDR_W-1:0]  res_rd,
   output logic [OP_W-1:0]    alu_ctrl,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   input  logic [DATA_W-1:0]  alu_x,
   input  logic               alu_cout
);

   state_t               state;
   logic [INSTR_W-1:0]   ir;
   logic [DATA_W-1:0]    rdata_a;
   logic [DATA_W-1:0]    rdata_b;
   logic                 ir_ld;
   logic [OP_W-1:0]      ir_op;
   logic [ADDR_W-1:0]    ir_rd;
   logic [DATA_W-1:0]    ir_imm;
   logic [DATA_W-1:0]    wr_data;
   logic                 wr_en;

   assign ir_ld   = ir[LD_POS];
   assign ir_op   = ir[OP_LSB +: OP_W];
   assign ir_rd   = ir[RD_LSB +: ADDR_W];
   assign ir_imm  = ir[IMM_LSB +: DATA_W];
   assign wr_data = ir_ld ? ir_imm : alu_x;
   assign wr_en   = (state == S_EXEC);

   // Operands are fetched as the instruction is accepted, so the ALU pins are
   // already registered and stable for the whole EXEC cycle.
   regfile4x4 u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .ra_addr (in_instr[RS1_LSB +: ADDR_W]),
      .ra_data (rdata_a),
      .rb_addr (in_instr[RS2_LSB +: ADDR_W]),
      .rb_data (rdata_b),
      .we      (wr_en),
      .wa      (ir_rd),
      .wd      (wr_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ir        <= '0;
         in_ready  <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_cout  <= 1'b0;
         res_rd    <= '0;
         alu_ctrl  <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  ir       <= in_instr;
                  alu_ctrl <= in_instr[OP_LSB +: OP_W];
                  alu_a    <= rdata_a;
                  alu_b    <= rdata_b;
                  in_ready <= 1'b0;
                  state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               res_data  <= wr_data;
               res_cout  <= !ir_ld && carry_valid(ir_op) && alu_cout;
               res_rd    <= ir_rd;
               res_valid <= 1'b1;
               state     <= S_WB;
            end
            S_WB: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b1;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer with a behavioural ALU and
// a transaction-level reference model checked every cycle.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [9:0] in_instr = '0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_data;
   logic       res_cout;
   logic [1:0] res_rd;
   logic [2:0] alu_ctrl;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_x;
   logic       alu_cout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_cout  (res_cout),
      .res_rd    (res_rd),
      .alu_ctrl  (alu_ctrl),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_x     (alu_x),
      .alu_cout  (alu_cout)
   );

   // External ALU; cout is deliberately junk for logic ops.
   function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [3:0] v;
      case (op)
         3'd0: return {1'b0, a} + {1'b0, b};
         3'd1: return {1'b0, a} - {1'b0, b};
         3'd2: v = a ^ b;
         3'd3: v = a | b;
         3'd4: v = a & b;
         3'd5: v = ~(a | b);
         3'd6: v = ~(a & b);
         default: v = ~(a ^ b);
      endcase
      return {~^v, v};
   endfunction

   logic [4:0] alu_out;
   always_comb alu_out = alu_fn(alu_ctrl, alu_a, alu_b);
   assign alu_x    = alu_out[3:0];
   assign alu_cout = alu_out[4];

   // Expected {cout, data} of one instruction given its operand values.
   function automatic logic [4:0] ref_exec(input logic [9:0] w, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] r;
      if (w[9]) return {1'b0, w[3:0]};
      r = alu_fn(w[8:6], a, b);
      if (w[8:6] <= 3'd1) return r;
      return {1'b0, r[3:0]};
   endfunction

   function automatic logic [9:0] enc(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2);
      return {ld, op, rd, rs1, rs2};
   endfunction

   function automatic logic [9:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
      return {1'b1, 3'b000, rd, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 executing, 2 result pending.
   int         m_ph;
   logic [9:0] m_ir;
   logic [3:0] m_r [4];
   logic [3:0] m_data;
   logic       m_cout;
   logic [1:0] m_rd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph <= 0;
         m_ir <= '0;
         for (int i = 0; i < 4; i++) m_r[i] <= '0;
      end else begin
         case (m_ph)
            0: if (in_valid) begin
               m_ir <= in_instr;
               m_ph <= 1;
            end
            1: begin
               {m_cout, m_data} <= ref_exec(m_ir, m_r[m_ir[3:2]], m_r[m_ir[1:0]]);
               m_r[m_ir[5:4]]   <= ref_exec(m_ir, m_r[m_ir[3:2]], m_r[m_ir[1:0]]) & 5'h0f;
               m_rd             <= m_ir[5:4];
               m_ph             <= 2;
            end
            default: if (res_ready) m_ph <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_res_valid", res_valid, 0);
         chk("rst_res", {res_data, res_cout, res_rd}, 0);
         chk("rst_alu", {alu_ctrl, alu_a, alu_b}, 0);
      end else begin
         chk("in_ready", in_ready, m_ph == 0);
         chk("res_valid", res_valid, m_ph == 2);
         if (m_ph == 1) begin
            chk("alu_ctrl", alu_ctrl, m_ir[8:6]);
            chk("alu_a", alu_a, m_r[m_ir[3:2]]);
            chk("alu_b", alu_b, m_r[m_ir[1:0]]);
         end
         if (m_ph == 2) begin
            chk("res_data", res_data, m_data);
            chk("res_cout", res_cout, m_cout);
            chk("res_rd", res_rd, m_rd);
         end
      end
   end

   // Issue one instruction, optionally stall the result, return it.
   task automatic run(input logic [9:0] w, input int stall, input logic hold_en,
                      input logic [9:0] hold_w, output logic [3:0] d, output logic c);
      int t;
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = w;
      res_ready = (stall == 0);
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("accept_timeout", 1, 0);
      @(negedge clk);
      in_valid = hold_en;
      in_instr = hold_en ? hold_w : w;
      t = 0;
      while (!res_valid && t < 10) begin @(negedge clk); t++; end
      if (t >= 10) chk("result_timeout", 1, 0);
      for (int i = 0; i < stall; i++) @(negedge clk);
      d = res_data;
      c = res_cout;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      logic [3:0] d;
      logic       c;
      logic [3:0] exp_logic [6];
      exp_logic = '{4'b0001, 4'b0101, 4'b0100, 4'b1010, 4'b1011, 4'b1110};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run(ldi(2'd0, 4'd8), 0, 1'b0, '0, d, c);
      chk("ld_R0_8", d, 4'd8);
      run(ldi(2'd1, 4'd1), 0, 1'b0, '0, d, c);
      run(enc(0, 3'd0, 2'd2, 2'd0, 2'd1), 0, 1'b0, '0, d, c);
      chk("add_9_data", {d, c}, {4'b1001, 1'b0});
      chk("add_9_rd_reg", m_r[2], 4'd9);

      run(ldi(2'd1, 4'd8), 0, 1'b0, '0, d, c);
      run(enc(0, 3'd0, 2'd2, 2'd0, 2'd1), 0, 1'b0, '0, d, c);
      chk("add_ovf", {d, c}, {4'b0000, 1'b1});

      run(ldi(2'd0, 4'd2), 0, 1'b0, '0, d, c);
      run(ldi(2'd1, 4'd3), 0, 1'b0, '0, d, c);
      run(enc(0, 3'd1, 2'd3, 2'd0, 2'd1), 0, 1'b0, '0, d, c);
      chk("sub_borrow", {d, c}, {4'b1111, 1'b1});
      run(enc(0, 3'd2, 2'd0, 2'd0, 2'd1), 0, 1'b0, '0, d, c);
      chk("xor_no_stale_carry", {d, c}, {4'b0001, 1'b0});

      run(ldi(2'd0, 4'd4), 0, 1'b0, '0, d, c);
      run(ldi(2'd1, 4'd5), 0, 1'b0, '0, d, c);
      for (int op = 2; op < 8; op++) begin
         run(enc(0, op[2:0], 2'd2, 2'd0, 2'd1), 0, 1'b0, '0, d, c);
         chk("logic_sweep", {d, c}, {exp_logic[op-2], 1'b0});
      end

      // Backpressure with the next instruction held on the input.
      run(enc(0, 3'd0, 2'd3, 2'd0, 2'd1), 4, 1'b1, ldi(2'd2, 4'd7), d, c);
      chk("bp_add", {d, c}, {4'd9, 1'b0});
      run(ldi(2'd2, 4'd7), 0, 1'b0, '0, d, c);
      chk("bp_held_ld", d, 4'd7);

      // Reset while an add is executing.
      run(ldi(2'd0, 4'd3), 0, 1'b0, '0, d, c);
      run(ldi(2'd1, 4'd4), 0, 1'b0, '0, d, c);
      in_valid = 1'b1;
      in_instr = enc(0, 3'd0, 2'd2, 2'd0, 2'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_res_valid", res_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
      run(ldi(2'd1, 4'd4), 0, 1'b0, '0, d, c);
      run(enc(0, 3'd0, 2'd3, 2'd2, 2'd1), 0, 1'b0, '0, d, c);
      chk("post_rst_R2_zero", {d, c}, {4'd4, 1'b0});

      // Free-running random traffic; the model follows every cycle.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 1) == 1);
         in_instr  = 10'($urandom);
         res_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      res_ready = 1'b1;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
